// File: rtl/i2c_target.sv
// I2C target (responder) for bus loopback and bring-up of the UART-to-I2C bridge.
// SCL/SDA are oversampled on clk_100M, synchronised and glitch-filtered. START and
// STOP are decoded from the filtered levels. A 7-bit address is matched, and bytes
// are exchanged with local logic over valid/ready streams. SCL is stretched while
// read data is not yet available.
module i2c_target #(
  parameter logic [6:0] ADDR       = 7'h42,
  parameter int         FILTER_LEN = 4
) (
  input  logic       clk_100M,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  // A new level is accepted on the FILTER_LEN-th consecutive differing sample.
  localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_LOAD     = 3'd5,
    ST_READ     = 3'd6,
    ST_RD_ACK   = 3'd7
  } state_t;

  // Line vectors: index 0 = SCL, index 1 = SDA.
  logic [1:0] meta_r;
  logic [1:0] sync_r;
  logic [1:0] flt_r;
  logic [1:0] prev_r;
  logic [3:0] filt_cnt_r [2];

  state_t     state_r;
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       rw_r;
  logic       ack_phase_r;
  logic       ack_pend_r;

  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic [7:0] byte_s;

  // Two-flop synchronisers bring the asynchronous pin levels into clk_100M.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 2'b11;
      sync_r <= 2'b11;
    end else begin
      meta_r <= {sda_i, scl_i};
      sync_r <= meta_r;
    end
  end

  // Glitch filters: the accepted level only follows a run of FILTER_LEN differing samples.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      flt_r         <= 2'b11;
      prev_r        <= 2'b11;
      filt_cnt_r[0] <= 4'd0;
      filt_cnt_r[1] <= 4'd0;
    end else begin
      prev_r <= flt_r;
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] != flt_r[i]) begin
          if (filt_cnt_r[i] == FILT_MAX) begin
            flt_r[i]      <= sync_r[i];
            filt_cnt_r[i] <= 4'd0;
          end else begin
            filt_cnt_r[i] <= filt_cnt_r[i] + 4'd1;
          end
        end else begin
          filt_cnt_r[i] <= 4'd0;
        end
      end
    end
  end

  // Bus events from the filtered levels; START/STOP need SCL high and take priority downstream.
  always_comb begin
    scl_rise_s = flt_r[0] & ~prev_r[0];
    scl_fall_s = ~flt_r[0] & prev_r[0];
    start_s    = prev_r[1] & ~flt_r[1] & flt_r[0];
    stop_s     = ~prev_r[1] & flt_r[1] & flt_r[0];
    byte_s     = {shift_r[6:0], flt_r[1]};
  end

  // Protocol FSM with registered line drivers, stream handshakes and status pulses.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      rw_r        <= 1'b0;
      ack_phase_r <= 1'b0;
      ack_pend_r  <= 1'b0;
      scl_oe      <= 1'b0;
      sda_oe      <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start_s) begin
        // START / repeated START: drop any partial byte and release both lines.
        state_r     <= ST_ADDR;
        bit_cnt_r   <= 3'd0;
        ack_phase_r <= 1'b0;
        scl_oe      <= 1'b0;
        sda_oe      <= 1'b0;
        start_det   <= 1'b1;
        busy        <= 1'b0;
      end else if (stop_s) begin
        state_r     <= ST_IDLE;
        ack_phase_r <= 1'b0;
        scl_oe      <= 1'b0;
        sda_oe      <= 1'b0;
        stop_det    <= 1'b1;
        busy        <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                rw_r        <= flt_r[1];
                ack_phase_r <= 1'b0;
                if (byte_s[7:1] == ADDR) begin
                  state_r <= ST_ADDR_ACK;
                  busy    <= 1'b1;
                end else begin
                  state_r <= ST_IDLE;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            // First fall starts the ACK slot, second fall ends it.
            if (scl_fall_s) begin
              if (!ack_phase_r) begin
                sda_oe      <= 1'b1;
                ack_phase_r <= 1'b1;
              end else begin
                sda_oe      <= 1'b0;
                ack_phase_r <= 1'b0;
                state_r     <= rw_r ? ST_LOAD : ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                ack_pend_r  <= rx_ready;
                ack_phase_r <= 1'b0;
                state_r     <= ST_WR_ACK;
                if (rx_ready) begin
                  rx_data  <= byte_s;
                  rx_valid <= 1'b1;
                end
              end
            end
          end
          ST_WR_ACK: begin
            // A refused byte leaves SDA released through the slot (NACK).
            if (scl_fall_s) begin
              if (!ack_phase_r) begin
                sda_oe      <= ack_pend_r;
                ack_phase_r <= 1'b1;
              end else begin
                sda_oe      <= 1'b0;
                ack_phase_r <= 1'b0;
                state_r     <= ST_WRITE;
              end
            end
          end
          ST_LOAD: begin
            // SCL is low here; hold it low until local logic supplies a byte.
            if (tx_valid) begin
              shift_r   <= tx_data;
              tx_ready  <= 1'b1;
              sda_oe    <= ~tx_data[7];
              bit_cnt_r <= 3'd0;
              state_r   <= ST_READ;
            end else begin
              scl_oe <= 1'b1;
            end
          end
          ST_READ: begin
            // Stretch is released one cycle after bit 7 is on SDA.
            scl_oe <= 1'b0;
            if (scl_fall_s) begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                sda_oe      <= 1'b0;
                ack_phase_r <= 1'b0;
                state_r     <= ST_RD_ACK;
              end else begin
                shift_r <= {shift_r[6:0], 1'b0};
                sda_oe  <= ~shift_r[6];
              end
            end
          end
          ST_RD_ACK: begin
            // NACK parks in IDLE (busy kept) until the controller issues STOP/START.
            if (scl_rise_s) begin
              if (flt_r[1]) begin
                state_r <= ST_IDLE;
              end else begin
                ack_phase_r <= 1'b1;
              end
            end else if (scl_fall_s && ack_phase_r) begin
              ack_phase_r <= 1'b0;
              state_r     <= ST_LOAD;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus-level controller model drives open-drain SCL/SDA,
// a table of write transactions, randomized transactions against a transaction
// model, and hand-written sequences for stretch, repeated START, abort and reset.
module tb_i2c_target;

  localparam int         Q          = 10;
  localparam logic [6:0] ADDR       = 7'h42;
  localparam int         FILTER_LEN = 4;

  logic       clk_100M = 1'b0;
  logic       rst_n;
  logic       scl_drv, sda_drv;
  logic       scl_oe, sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       start_det, stop_det, busy;
  logic       scl_line, sda_line;

  assign scl_line = scl_drv & ~scl_oe;
  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk_100M = ~clk_100M;

  i2c_target #(.ADDR(ADDR), .FILTER_LEN(FILTER_LEN)) dut (
    .clk_100M(clk_100M), .rst_n(rst_n), .scl_i(scl_line), .sda_i(sda_line),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .start_det(start_det), .stop_det(stop_det), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_rxv = 0, n_txr = 0, n_start = 0, n_stop = 0, n_sda = 0, n_busy = 0, n_strch = 0;
  logic [7:0] rx_log [256];
  int s_rxv, s_txr, s_start, s_stop, s_sda, s_busy, s_strch;

  // Event monitor: counts pulses and logs received bytes, sampled on the falling edge.
  always @(negedge clk_100M) begin
    if (rx_valid === 1'b1) begin
      rx_log[n_rxv[7:0]] <= rx_data;
      n_rxv <= n_rxv + 1;
    end
    if (tx_ready === 1'b1) n_txr <= n_txr + 1;
    if (start_det === 1'b1) n_start <= n_start + 1;
    if (stop_det === 1'b1) n_stop <= n_stop + 1;
    if (sda_oe === 1'b1) n_sda <= n_sda + 1;
    if (busy === 1'b1) n_busy <= n_busy + 1;
    if (scl_oe === 1'b1) n_strch <= n_strch + 1;
  end

  // Watchdog: never let the run hang.
  initial begin
    repeat (95000) @(negedge clk_100M);
    $display("FAIL watchdog: got no end of test, expected finish within 95000 cycles");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected event within bound", name);
  endtask

  task automatic snap();
    s_rxv = n_rxv; s_txr = n_txr; s_start = n_start; s_stop = n_stop;
    s_sda = n_sda; s_busy = n_busy; s_strch = n_strch;
  endtask

  task automatic q();
    repeat (Q) @(negedge clk_100M);
  endtask

  task automatic scl_release();
    int k;
    scl_drv = 1'b1;
    @(negedge clk_100M);
    k = 0;
    while (scl_line !== 1'b1 && k < 3000) begin
      @(negedge clk_100M);
      k++;
    end
    if (scl_line !== 1'b1) expire("scl_release");
  endtask

  task automatic do_start();
    sda_drv = 1'b1; q(); scl_release(); q(); sda_drv = 1'b0; q(); scl_drv = 1'b0; q();
  endtask

  task automatic do_stop();
    sda_drv = 1'b0; q(); scl_release(); q(); sda_drv = 1'b1; q();
  endtask

  task automatic bit_xfer(input logic b, output logic got);
    sda_drv = b; q(); scl_release(); q(); got = sda_line; scl_drv = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic t;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], t);
    bit_xfer(1'b1, t);
    acked = ~t;
  endtask

  task automatic read_byte(input logic ack_it, output logic [7:0] d);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, t);
      d[i] = t;
    end
    bit_xfer(~ack_it, t);
  endtask

  task automatic read_provided(input logic provide, input logic [7:0] txb, input int dly,
                               input logic ack_it, output logic [7:0] d);
    logic [7:0] r;
    fork
      begin
        if (provide) begin
          int k;
          repeat (dly) @(negedge clk_100M);
          tx_data  = txb;
          tx_valid = 1'b1;
          k = 0;
          while (tx_ready !== 1'b1 && k < 4000) begin
            @(negedge clk_100M);
            k++;
          end
          if (tx_ready !== 1'b1) expire("tx_ready");
          tx_valid = 1'b0;
        end
      end
      begin
        read_byte(ack_it, r);
      end
    join
    d = r;
  endtask

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] data;
    logic       rdy;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_rx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic       a, b;
    logic [7:0] d, d2;

    rst_n = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk_100M);
    check("rst_scl_oe", 32'(scl_oe), 32'(1'b0));
    check("rst_sda_oe", 32'(sda_oe), 32'(1'b0));
    check("rst_rx_data", 32'(rx_data), 32'(8'h00));
    check("rst_rx_valid", 32'(rx_valid), 32'(1'b0));
    check("rst_tx_ready", 32'(tx_ready), 32'(1'b0));
    check("rst_start_det", 32'(start_det), 32'(1'b0));
    check("rst_stop_det", 32'(stop_det), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk_100M);

    // Table: START, address byte, one data byte, STOP.
    vecs[0] = '{8'h84, 8'hA5, 1'b1, 1'b1, 1'b1, 1};
    vecs[1] = '{8'h86, 8'h5A, 1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{8'h84, 8'h3C, 1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h84, 8'hFF, 1'b1, 1'b1, 1'b1, 1};
    vecs[4] = '{8'h04, 8'h12, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{8'hC4, 8'h00, 1'b1, 1'b0, 1'b0, 0};
    vecs[6] = '{8'h84, 8'h00, 1'b1, 1'b1, 1'b1, 1};
    for (int v = 0; v < 7; v++) begin
      snap();
      rx_ready = 1'b0;
      do_start();
      write_byte(vecs[v].addr_b, a);
      rx_ready = vecs[v].rdy;
      write_byte(vecs[v].data, b);
      do_stop();
      rx_ready = 1'b0;
      check($sformatf("vec%0d_addr_ack", v), 32'(a), 32'(vecs[v].exp_aack));
      check($sformatf("vec%0d_data_ack", v), 32'(b), 32'(vecs[v].exp_dack));
      check($sformatf("vec%0d_rx_count", v), n_rxv - s_rxv, vecs[v].exp_rx);
      if (vecs[v].exp_rx == 1)
        check($sformatf("vec%0d_rx_data", v), 32'(rx_log[8'(n_rxv - 1)]), 32'(vecs[v].data));
      check($sformatf("vec%0d_start", v), n_start - s_start, 1);
      check($sformatf("vec%0d_stop", v), n_stop - s_stop, 1);
      check($sformatf("vec%0d_busy_seen", v), 32'(n_busy > s_busy), 32'(vecs[v].exp_aack));
      check($sformatf("vec%0d_sda_seen", v), 32'(n_sda > s_sda), 32'(vecs[v].exp_aack));
      check($sformatf("vec%0d_busy_end", v), 32'(busy), 32'(1'b0));
    end

    // Randomized transactions against the transaction-level model.
    for (int t = 0; t < 14; t++) begin
      logic       match, rw;
      logic [6:0] ad;
      int         nb;
      logic [7:0] exp_rx_q [$];
      match = ($urandom_range(0, 2) != 0);
      ad    = match ? ADDR : 7'($urandom_range(0, 127));
      if (ad == ADDR && !match) ad = ad ^ 7'h01;
      rw = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      exp_rx_q.delete();
      snap();
      do_start();
      write_byte({ad, rw}, a);
      check($sformatf("rnd%0d_addr_ack", t), 32'(a), 32'(match));
      for (int i = 0; i < nb; i++) begin
        if (!rw) begin
          logic [7:0] db;
          logic       rdy;
          db  = 8'($urandom_range(0, 255));
          rdy = 1'($urandom_range(0, 1));
          rx_ready = rdy;
          write_byte(db, b);
          rx_ready = 1'b0;
          check($sformatf("rnd%0d_wack%0d", t, i), 32'(b), 32'(match & rdy));
          if (match && rdy) exp_rx_q.push_back(db);
        end else begin
          logic [7:0] tb;
          tb = 8'($urandom_range(0, 255));
          read_provided(match, tb, $urandom_range(0, 40), (i != nb - 1), d);
          check($sformatf("rnd%0d_rd%0d", t, i), 32'(d), 32'(match ? tb : 8'hFF));
        end
      end
      do_stop();
      check($sformatf("rnd%0d_rx_count", t), n_rxv - s_rxv, exp_rx_q.size());
      for (int i = 0; i < exp_rx_q.size(); i++)
        check($sformatf("rnd%0d_rx%0d", t, i), 32'(rx_log[8'(s_rxv + i)]), 32'(exp_rx_q[i]));
      check($sformatf("rnd%0d_tx_ready", t), n_txr - s_txr, (match && rw) ? nb : 0);
      check($sformatf("rnd%0d_start_stop", t), (n_start - s_start) + 16 * (n_stop - s_stop), 17);
      check($sformatf("rnd%0d_busy_seen", t), 32'(n_busy > s_busy), 32'(match));
    end

    // Read with stretch: data arrives 50 cycles after LOAD.
    snap();
    do_start();
    write_byte(8'h85, a);
    check("rd_addr_ack", 32'(a), 32'(1'b1));
    read_provided(1'b1, 8'h3C, 50, 1'b0, d);
    do_stop();
    check("rd_byte", 32'(d), 32'(8'h3C));
    check("rd_tx_ready", n_txr - s_txr, 1);
    check("rd_stretch_len", 32'((n_strch - s_strch) >= 45 && (n_strch - s_strch) <= 62), 32'(1'b1));
    check("rd_scl_released", 32'(scl_oe), 32'(1'b0));
    check("rd_busy_end", 32'(busy), 32'(1'b0));

    // Repeated START: write 0x11, Sr, read two bytes (ACK then NACK).
    snap();
    do_start();
    write_byte(8'h84, a);
    rx_ready = 1'b1;
    write_byte(8'h11, b);
    rx_ready = 1'b0;
    check("sr_wr_ack", 32'({a, b}), 32'(2'b11));
    do_start();
    write_byte(8'h85, a);
    check("sr_rd_addr_ack", 32'(a), 32'(1'b1));
    read_provided(1'b1, 8'h77, 5, 1'b1, d);
    read_provided(1'b1, 8'h88, 5, 1'b0, d2);
    do_stop();
    check("sr_rx_count", n_rxv - s_rxv, 1);
    check("sr_rx_data", 32'(rx_data), 32'(8'h11));
    check("sr_rd0", 32'(d), 32'(8'h77));
    check("sr_rd1", 32'(d2), 32'(8'h88));
    check("sr_tx_ready", n_txr - s_txr, 2);
    check("sr_start_count", n_start - s_start, 2);
    check("sr_stop_count", n_stop - s_stop, 1);

    // Abort mid-byte: STOP after four data bits.
    snap();
    do_start();
    write_byte(8'h84, a);
    rx_ready = 1'b1;
    bit_xfer(1'b1, b); bit_xfer(1'b0, b); bit_xfer(1'b1, b); bit_xfer(1'b0, b);
    do_stop();
    rx_ready = 1'b0;
    check("abort_rx_count", n_rxv - s_rxv, 0);
    check("abort_lines", 32'({scl_oe, sda_oe}), 32'(2'b00));
    check("abort_busy", 32'(busy), 32'(1'b0));
    // Back-pressure: data byte refused.
    snap();
    do_start();
    write_byte(8'h84, a);
    rx_ready = 1'b0;
    write_byte(8'h55, b);
    do_stop();
    check("bp_acks", 32'({a, b}), 32'(2'b10));
    check("bp_rx_count", n_rxv - s_rxv, 0);

    // Async reset while stretching.
    do_start();
    write_byte(8'h85, a);
    for (int k = 0; k < 100 && scl_oe !== 1'b1; k++) @(negedge clk_100M);
    check("rst_pre_stretch", 32'(scl_oe), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    check("rst_async_scl_oe", 32'(scl_oe), 32'(1'b0));
    check("rst_async_sda_oe", 32'(sda_oe), 32'(1'b0));
    check("rst_async_busy", 32'(busy), 32'(1'b0));
    @(negedge clk_100M);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_100M);
    do_stop();
    repeat (10) @(negedge clk_100M);

    // SDA glitch of FILTER_LEN-1 cycles while SCL high: filtered out.
    snap();
    sda_drv = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk_100M);
    sda_drv = 1'b1;
    repeat (20) @(negedge clk_100M);
    check("glitch_no_start", n_start - s_start, 0);
    // A low pulse long enough to pass the filter is a START (then STOP).
    sda_drv = 1'b0;
    repeat (FILTER_LEN + 2) @(negedge clk_100M);
    sda_drv = 1'b1;
    repeat (20) @(negedge clk_100M);
    check("long_pulse_start", n_start - s_start, 1);
    check("long_pulse_stop", n_stop - s_stop, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
